crc8_serial: RTL
================

# crc8_serial

Bit-serial CRC-8 engine that accepts bytes over a valid/ready handshake and folds them MSB-first through an XOR-feedback shift register. It sits downstream of the basic XOR gate stage and is the first sequential consumer of that XOR primitive. It produces a frame checksum for the link/packet layer: one CRC per frame, delimited by `in_last`.

## Interface
Parameters:
- `POLY`, 8'h07, generator polynomial with the implicit x^8 term omitted.
- `INIT`, 8'h00, CRC seed loaded at the first byte of every frame.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  upstream byte available.
- `in_ready`  out  1  engine can accept a byte this cycle.
- `in_data`  in  8  byte to fold in, processed MSB first.
- `in_last`  in  1  the accepted byte is the final byte of the frame.
- `crc_valid`  out  1  one-cycle pulse; `crc_out` holds the finished frame CRC.
- `crc_out`  out  8  CRC register; holds the last result until the next frame's first byte.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: 8 cycles, `in_ready`=0.
  - DONE: 1 cycle, `crc_valid`=1, `in_ready`=0.
- Accept happens when `in_valid && in_ready` in IDLE. On accept:
  - latch `in_data` into the shift register and `in_last` into `last_q`;
  - clear the bit counter;
  - go to SHIFT.
- Frame seeding: an internal `frame_active` flag is 0 after reset and after DONE.
  - An accept with `frame_active`=0 loads `crc` with `INIT` and sets `frame_active`.
  - An accept with `frame_active`=1 keeps `crc` unchanged.
- Each SHIFT cycle performs one bit step:
  - `fb = crc[7] ^ data[7]`
  - `crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00)`
  - `data <= data << 1`
  - increment the bit counter
- SHIFT exit, after the 8th step (bit counter = 7):
  - `last_q`=1 → DONE;
  - otherwise → IDLE.
- DONE → IDLE unconditionally. `frame_active` is cleared in DONE.
- `in_data` and `in_last` are ignored whenever `in_ready`=0. `in_valid` may stay high; no byte is lost or duplicated.
- Single-byte frame: a byte with `in_last`=1 and `frame_active`=0 is seeded and finished normally.
- `crc_out` is always the live CRC register. Consumers sample it only when `crc_valid`=1.
- Reset values: state IDLE, `crc`=`INIT`, shift register 0, counter 0, `frame_active`=0, `last_q`=0.
- Resulting outputs in reset: `in_ready`=1, `crc_valid`=0, `busy`=0, `crc_out`=`INIT`.
- Reset asserted mid-SHIFT or in DONE aborts the frame immediately and asynchronously. No `crc_valid` is produced for the aborted frame.

## Timing
- Accept at cycle T: SHIFT occupies T+1..T+8, and `in_ready`=0 over those cycles.
- Non-last byte: IDLE at T+9, so the earliest next accept is T+9. Throughput is 1 byte per 9 cycles.
- Last byte: DONE at T+9, with `crc_valid`=1 and the final CRC on `crc_out`. IDLE at T+10.
- Latency from accept of the last byte to `crc_valid` is 9 cycles.
- `in_ready` and `busy` are decoded from registered state only, with no combinational path from `in_valid`.

## Structure
- Package `crc_pkg` holds:
  - the state enum `crc_state_t` (IDLE, SHIFT, DONE);
  - constants `CRC8_POLY_DEFAULT`=8'h07 and `CRC8_INIT_DEFAULT`=8'h00;
  - the bit-counter width (3).
- Sub-module `crc8_bit_step`: purely combinational single-bit update.
  - Inputs: `crc_in[7:0]`, `bit_in`, `POLY`.
  - Output: `crc_nxt`.
  - Built on the XOR feedback term.
- `crc8_serial` holds the FSM, counter, registers and one `crc8_bit_step` instance.

## Test plan
- Reset check: assert `rst` asynchronously → `in_ready`=1, `crc_valid`=0, `busy`=0 and `crc_out`=8'h00, all without waiting for a clock edge.
- Single-byte frames, checking `crc_valid` at exactly T+9 in each case:
  - 8'h01 with `in_last`=1 → `crc_out`=8'h07;
  - 8'h80 → 8'h89;
  - 8'h00 → 8'h00.
- Multi-byte frame: ASCII "123456789" (8'h31..8'h39), with `in_last` on 8'h39 → `crc_valid` once, `crc_out`=8'hF4.
- Handshake: hold `in_valid`=1 continuously and change `in_data` during SHIFT → bytes are accepted only every 9th cycle, mid-SHIFT data is ignored, and the CRC still matches the reference.
- Back-to-back frames: "123456789" immediately followed by single byte 8'h01 → second `crc_out`=8'h07, which proves reseed to `INIT`.
- Reset mid-operation: assert `rst` at SHIFT bit 4 of a non-final byte, then send 8'h01 with `in_last` → `crc_out`=8'h07 and no stale `crc_valid`.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared types and constants for the bit-serial CRC-8 engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } crc_state_t;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;
  localparam int         CNT_W             = 3;

endpackage

// File: rtl/crc8_bit_step.sv
// One MSB-first CRC-8 bit update, combinational.
module crc8_bit_step
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [7:0] crc_in,
  input  logic       bit_in,
  output logic [7:0] crc_nxt
);

  logic fb;

  assign fb      = crc_in[7] ^ bit_in;
  assign crc_nxt = {crc_in[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

endmodule

// File: rtl/crc8_serial.sv
// Byte-in, bit-serial CRC-8 engine with a valid/ready input
// and a one-cycle crc_valid pulse per in_last-delimited frame.
module crc8_serial
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       crc_valid,
  output logic [7:0] crc_out,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  crc_state_t       state_q, state_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_active_q, frame_active_d;
  logic             last_q, last_d;
  logic [7:0]       crc_step;

  crc8_bit_step #(
    .POLY(POLY)
  ) u_step (
    .crc_in (crc_q),
    .bit_in (data_q[7]),
    .crc_nxt(crc_step)
  );

  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    data_d         = data_q;
    cnt_d          = cnt_q;
    frame_active_d = frame_active_q;
    last_d         = last_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          cnt_d   = '0;
          state_d = SHIFT;
          if (!frame_active_q) begin
            crc_d          = INIT;
            frame_active_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        crc_d  = crc_step;
        data_d = {data_q[6:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        frame_active_d = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      crc_q          <= INIT;
      data_q         <= '0;
      cnt_q          <= '0;
      frame_active_q <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      data_q         <= data_d;
      cnt_q          <= cnt_d;
      frame_active_q <= frame_active_d;
      last_q         <= last_d;
    end
  end

  // Handshake and status decode from registered state only.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign crc_valid = (state_q == DONE);
  assign crc_out   = crc_q;

endmodule
